// File: rtl/eth_dma_avl_arbiter.sv
// Two-requester round-robin arbiter in front of the Ethernet DMA Avalon-MM
// master. Ownership lasts for a whole write burst, or for a read command plus
// every read-data beat that belongs to it. Read data is routed to the owner.
module eth_dma_avl_arbiter #(
  parameter int pADDR_WIDTH  = 32,
  parameter int pDATA_WIDTH  = 64,
  parameter int pBURST_WIDTH = 8
) (
  input  logic                    avl_clock,
  input  logic                    avl_rst_n,
  // requester 0
  input  logic [pADDR_WIDTH-1:0]  s0_dma_avl_addr,
  input  logic                    s0_dma_avl_rdena,
  input  logic                    s0_dma_avl_wrena,
  input  logic [pDATA_WIDTH-1:0]  s0_dma_avl_wrdata,
  input  logic [pBURST_WIDTH-1:0] s0_dma_avl_burst_cnt,
  output logic                    s0_dma_avl_wrq,
  output logic [pDATA_WIDTH-1:0]  s0_dma_avl_rddata,
  output logic                    s0_dma_avl_rddataval,
  // requester 1
  input  logic [pADDR_WIDTH-1:0]  s1_dma_avl_addr,
  input  logic                    s1_dma_avl_rdena,
  input  logic                    s1_dma_avl_wrena,
  input  logic [pDATA_WIDTH-1:0]  s1_dma_avl_wrdata,
  input  logic [pBURST_WIDTH-1:0] s1_dma_avl_burst_cnt,
  output logic                    s1_dma_avl_wrq,
  output logic [pDATA_WIDTH-1:0]  s1_dma_avl_rddata,
  output logic                    s1_dma_avl_rddataval,
  // shared master
  output logic [pADDR_WIDTH-1:0]  m_dma_avl_addr,
  output logic                    m_dma_avl_rdena,
  output logic                    m_dma_avl_wrena,
  output logic [pDATA_WIDTH-1:0]  m_dma_avl_wrdata,
  output logic [pBURST_WIDTH-1:0] m_dma_avl_burst_cnt,
  input  logic                    m_dma_avl_wrq,
  input  logic [pDATA_WIDTH-1:0]  m_dma_avl_rddata,
  input  logic                    m_dma_avl_rddataval,
  // status
  output logic                    arb_grant,
  output logic                    arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_CMD   = 2'd2,
    ST_RD_DATA  = 2'd3
  } state_t;

  localparam logic [pBURST_WIDTH-1:0] BURST_ONE = pBURST_WIDTH'(1);

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic [pBURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [pBURST_WIDTH-1:0] burst_len_q, burst_len_d;

  logic                    req0, req1, grant_sel;
  logic                    sel_wrena;
  logic [pBURST_WIDTH-1:0] sel_burst;
  logic                    own_rdena, own_wrena;
  logic                    last_beat;

  // Arbitration candidate: a lone requester wins, otherwise alternate.
  assign req0      = s0_dma_avl_rdena | s0_dma_avl_wrena;
  assign req1      = s1_dma_avl_rdena | s1_dma_avl_wrena;
  assign grant_sel = (req0 & req1) ? ~last_grant_q : req1;
  assign sel_wrena = grant_sel ? s1_dma_avl_wrena     : s0_dma_avl_wrena;
  assign sel_burst = grant_sel ? s1_dma_avl_burst_cnt : s0_dma_avl_burst_cnt;

  // Owner's command fields; strobes are gated by state below.
  assign own_rdena           = owner_q ? s1_dma_avl_rdena     : s0_dma_avl_rdena;
  assign own_wrena           = owner_q ? s1_dma_avl_wrena     : s0_dma_avl_wrena;
  assign m_dma_avl_addr      = owner_q ? s1_dma_avl_addr      : s0_dma_avl_addr;
  assign m_dma_avl_wrdata    = owner_q ? s1_dma_avl_wrdata    : s0_dma_avl_wrdata;
  assign m_dma_avl_burst_cnt = owner_q ? s1_dma_avl_burst_cnt : s0_dma_avl_burst_cnt;

  // Read data is broadcast; only the valid strobe is steered.
  assign s0_dma_avl_rddata = m_dma_avl_rddata;
  assign s1_dma_avl_rddata = m_dma_avl_rddata;

  assign last_beat = (beat_cnt_q == burst_len_q - BURST_ONE);
  assign arb_grant = owner_q;
  assign arb_busy  = (state_q != ST_IDLE);

  // State and ownership registers; reset abandons any transfer in flight.
  always_ff @(posedge avl_clock or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      burst_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_len_q  <= burst_len_d;
    end
  end

  // Next-state, beat counting and handshake steering.
  always_comb begin
    state_d              = state_q;
    owner_d              = owner_q;
    last_grant_d         = last_grant_q;
    beat_cnt_d           = beat_cnt_q;
    burst_len_d          = burst_len_q;
    m_dma_avl_rdena      = 1'b0;
    m_dma_avl_wrena      = 1'b0;
    s0_dma_avl_wrq       = 1'b1;
    s1_dma_avl_wrq       = 1'b1;
    s0_dma_avl_rddataval = 1'b0;
    s1_dma_avl_rddataval = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          beat_cnt_d   = '0;
          // A zero burst count still moves one beat.
          burst_len_d  = (sel_burst == '0) ? BURST_ONE : sel_burst;
          // Write wins if a requester illegally asserts both strobes.
          state_d      = sel_wrena ? ST_WR_BURST : ST_RD_CMD;
        end
      end

      ST_WR_BURST: begin
        m_dma_avl_rdena = own_rdena;
        m_dma_avl_wrena = own_wrena;
        if (owner_q) s1_dma_avl_wrq = m_dma_avl_wrq;
        else         s0_dma_avl_wrq = m_dma_avl_wrq;
        if (own_wrena && !m_dma_avl_wrq) begin
          beat_cnt_d = beat_cnt_q + BURST_ONE;
          if (last_beat) state_d = ST_IDLE;
        end
      end

      ST_RD_CMD: begin
        m_dma_avl_rdena = own_rdena;
        m_dma_avl_wrena = own_wrena;
        if (owner_q) s1_dma_avl_wrq = m_dma_avl_wrq;
        else         s0_dma_avl_wrq = m_dma_avl_wrq;
        if (own_rdena && !m_dma_avl_wrq) state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        if (owner_q) s1_dma_avl_rddataval = m_dma_avl_rddataval;
        else         s0_dma_avl_rddataval = m_dma_avl_rddataval;
        if (m_dma_avl_rddataval) begin
          beat_cnt_d = beat_cnt_q + BURST_ONE;
          if (last_beat) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_dma_avl_arbiter.sv
// Directed bench for eth_dma_avl_arbiter. Inputs change 1 ns after a rising
// edge; outputs are sampled on the falling edge.
module tb_eth_dma_avl_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] s0_addr, s1_addr, m_addr;
  logic          s0_rdena, s1_rdena, s0_wrena, s1_wrena;
  logic [DW-1:0] s0_wrdata, s1_wrdata, m_wrdata;
  logic [BW-1:0] s0_burst, s1_burst, m_burst;
  logic          s0_wrq, s1_wrq, m_wrq;
  logic [DW-1:0] s0_rddata, s1_rddata, m_rddata;
  logic          s0_rdval, s1_rdval, m_rdval;
  logic          m_rdena, m_wrena;
  logic          arb_grant, arb_busy;

  int n_vec = 0;
  int n_err = 0;
  int cnt0, cnt1;

  always #5 clk = ~clk;

  eth_dma_avl_arbiter #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .pBURST_WIDTH(BW)
  ) dut (
    .avl_clock           (clk),
    .avl_rst_n           (rst_n),
    .s0_dma_avl_addr     (s0_addr),
    .s0_dma_avl_rdena    (s0_rdena),
    .s0_dma_avl_wrena    (s0_wrena),
    .s0_dma_avl_wrdata   (s0_wrdata),
    .s0_dma_avl_burst_cnt(s0_burst),
    .s0_dma_avl_wrq      (s0_wrq),
    .s0_dma_avl_rddata   (s0_rddata),
    .s0_dma_avl_rddataval(s0_rdval),
    .s1_dma_avl_addr     (s1_addr),
    .s1_dma_avl_rdena    (s1_rdena),
    .s1_dma_avl_wrena    (s1_wrena),
    .s1_dma_avl_wrdata   (s1_wrdata),
    .s1_dma_avl_burst_cnt(s1_burst),
    .s1_dma_avl_wrq      (s1_wrq),
    .s1_dma_avl_rddata   (s1_rddata),
    .s1_dma_avl_rddataval(s1_rdval),
    .m_dma_avl_addr      (m_addr),
    .m_dma_avl_rdena     (m_rdena),
    .m_dma_avl_wrena     (m_wrena),
    .m_dma_avl_wrdata    (m_wrdata),
    .m_dma_avl_burst_cnt (m_burst),
    .m_dma_avl_wrq       (m_wrq),
    .m_dma_avl_rddata    (m_rddata),
    .m_dma_avl_rddataval (m_rdval),
    .arb_grant           (arb_grant),
    .arb_busy            (arb_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    s0_addr = 32'h1000; s1_addr = 32'h2000;
    s0_rdena = 0; s1_rdena = 0; s0_wrena = 0; s1_wrena = 0;
    s0_wrdata = '0; s1_wrdata = '0; s0_burst = '0; s1_burst = '0;
    m_wrq = 0; m_rddata = 64'hDEAD; m_rdval = 1'b1;

    // ---------------- reset state (stray rddataval ignored) ----------------
    #2;
    chk("rst_m_wrena", m_wrena, 1'b0);
    chk("rst_m_rdena", m_rdena, 1'b0);
    chk("rst_s0_wrq", s0_wrq, 1'b1);
    chk("rst_s1_wrq", s1_wrq, 1'b1);
    chk("rst_s0_rdval", s0_rdval, 1'b0);
    chk("rst_s1_rdval", s1_rdval, 1'b0);
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_grant", arb_grant, 1'b0);
    m_rdval = 1'b0;
    to_neg(); to_neg();
    rst_n = 1'b1;
    $display("reset checks done");

    // ---------------- contention from reset ----------------
    to_pos();
    s0_wrena = 1; s0_burst = 1; s0_wrdata = 64'hC0;
    s1_wrena = 1; s1_burst = 1; s1_wrdata = 64'hC1;
    to_neg();
    chk("cont_pre_busy", arb_busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      to_neg();
      chk("cont_busy", arb_busy, 1'b1);
      chk("cont_grant", arb_grant, k[0]);
      chk("cont_wrdata", m_wrdata, k[0] ? 64'hC1 : 64'hC0);
      to_neg();
      chk("cont_gap", arb_busy, 1'b0);
      $display("contention grant %0d to port %0d", k, k[0]);
    end
    s0_wrena = 0; s1_wrena = 0;

    // ---------------- single write burst of 4 ----------------
    to_pos();
    s0_wrena = 1; s0_burst = 4; s0_addr = 32'h1000; s0_wrdata = 64'hA0;
    to_neg();
    chk("wr_lat_busy", arb_busy, 1'b0);
    chk("wr_lat_s0_wrq", s0_wrq, 1'b1);
    chk("wr_lat_m_wrena", m_wrena, 1'b0);
    to_pos();
    for (int b = 0; b < 4; b++) begin
      s0_wrdata = 64'hA0 + 64'(b);
      to_neg();
      chk("wr_m_wrena", m_wrena, 1'b1);
      chk("wr_m_addr", m_addr, 32'h1000);
      chk("wr_m_wrdata", m_wrdata, 64'hA0 + 64'(b));
      chk("wr_s0_wrq", s0_wrq, 1'b0);
      chk("wr_s1_wrq", s1_wrq, 1'b1);
      chk("wr_grant", arb_grant, 1'b0);
      to_pos();
    end
    s0_wrena = 0;
    to_neg();
    chk("wr_done_busy", arb_busy, 1'b0);
    chk("wr_done_m_wrena", m_wrena, 1'b0);
    $display("single write burst 4 done");

    // ---------------- read routing, s1 burst 3 ----------------
    to_pos();
    s1_rdena = 1; s1_burst = 3; s1_addr = 32'h2040; m_wrq = 1;
    to_pos();
    for (int c = 0; c < 2; c++) begin
      to_neg();
      chk("rd_cmd_rdena", m_rdena, 1'b1);
      chk("rd_cmd_addr", m_addr, 32'h2040);
      chk("rd_cmd_s1_wrq", s1_wrq, 1'b1);
      chk("rd_cmd_s0_wrq", s0_wrq, 1'b1);
      chk("rd_cmd_grant", arb_grant, 1'b1);
      to_pos();
    end
    m_wrq = 0;
    to_neg();
    chk("rd_acc_s1_wrq", s1_wrq, 1'b0);
    chk("rd_acc_rdena", m_rdena, 1'b1);
    to_pos();
    s1_rdena = 0;
    to_neg();
    chk("rd_data_rdena", m_rdena, 1'b0);
    chk("rd_data_s1_wrq", s1_wrq, 1'b1);
    chk("rd_data_busy", arb_busy, 1'b1);
    for (int b = 0; b < 3; b++) begin
      to_pos();
      m_rdval = 1; m_rddata = 64'hB0 + 64'(b);
      to_neg();
      chk("rd_s1_rdval", s1_rdval, 1'b1);
      chk("rd_s0_rdval", s0_rdval, 1'b0);
      chk("rd_s1_rddata", s1_rddata, 64'hB0 + 64'(b));
      if (b == 0) begin
        to_pos();
        m_rdval = 0;
        to_neg();
        chk("rd_gap_rdval", s1_rdval, 1'b0);
        chk("rd_gap_busy", arb_busy, 1'b1);
      end
    end
    to_pos();
    m_rdval = 0;
    to_neg();
    chk("rd_done_busy", arb_busy, 1'b0);
    $display("read routing burst 3 done");

    // ---------------- stall mid-burst, s1 waiting ----------------
    to_pos();
    s0_wrena = 1; s0_burst = 4;
    s1_rdena = 1; s1_burst = 1;
    to_pos();
    to_neg();
    chk("stall_b1_grant", arb_grant, 1'b0);
    to_pos();
    m_wrq = 1;
    for (int c = 0; c < 5; c++) begin
      to_neg();
      chk("stall_grant", arb_grant, 1'b0);
      chk("stall_busy", arb_busy, 1'b1);
      chk("stall_s0_wrq", s0_wrq, 1'b1);
      chk("stall_s1_wrq", s1_wrq, 1'b1);
      to_pos();
    end
    m_wrq = 0;
    for (int b = 1; b < 4; b++) begin
      to_neg();
      chk("stall_rest_grant", arb_grant, 1'b0);
      chk("stall_rest_s0_wrq", s0_wrq, 1'b0);
      to_pos();
    end
    s0_wrena = 0;
    to_neg();
    chk("stall_gap_busy", arb_busy, 1'b0);
    to_pos();
    to_neg();
    chk("stall_s1_grant", arb_grant, 1'b1);
    chk("stall_s1_rdena", m_rdena, 1'b1);
    to_pos();
    s1_rdena = 0; m_rdval = 1; m_rddata = 64'hE1;
    to_neg();
    chk("stall_s1_rdval", s1_rdval, 1'b1);
    to_pos();
    m_rdval = 0;
    to_neg();
    chk("stall_done_busy", arb_busy, 1'b0);
    $display("stall mid-burst done");

    // ---------------- burst_cnt 0 => single beat ----------------
    to_pos();
    s0_wrena = 1; s0_burst = 0;
    to_pos();
    to_neg();
    chk("b0_busy", arb_busy, 1'b1);
    chk("b0_m_burst", m_burst, 8'd0);
    to_pos();
    s0_wrena = 0;
    to_neg();
    chk("b0_done_busy", arb_busy, 1'b0);
    $display("burst_cnt 0 write done");

    // ---------------- burst_cnt 255 read ----------------
    to_pos();
    s0_rdena = 1; s0_burst = 8'd255;
    to_pos();
    to_neg();
    chk("b255_m_burst", m_burst, 8'd255);
    chk("b255_rdena", m_rdena, 1'b1);
    to_pos();
    s0_rdena = 0; m_rdval = 1;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 255; i++) begin
      m_rddata = 64'(i);
      to_neg();
      if (s0_rdval) cnt0++;
      if (s1_rdval) cnt1++;
      if (i == 254) chk("b255_busy_last", arb_busy, 1'b1);
      to_pos();
    end
    m_rdval = 0;
    to_neg();
    chk("b255_s0_beats", 64'(cnt0), 64'd255);
    chk("b255_s1_beats", 64'(cnt1), 64'd0);
    chk("b255_done_busy", arb_busy, 1'b0);
    $display("burst_cnt 255 read done");

    // ---------------- reset mid-burst ----------------
    to_pos();
    s0_wrena = 1; s0_burst = 8;
    to_pos();
    for (int b = 0; b < 3; b++) begin
      to_neg();
      to_pos();
    end
    rst_n = 0;
    #1;
    chk("mrst_m_wrena", m_wrena, 1'b0);
    chk("mrst_s0_wrq", s0_wrq, 1'b1);
    chk("mrst_s1_wrq", s1_wrq, 1'b1);
    chk("mrst_busy", arb_busy, 1'b0);
    s1_wrena = 1; s1_burst = 1;
    to_neg(); to_neg();
    rst_n = 1;
    to_neg();
    chk("mrst_regrant_busy", arb_busy, 1'b1);
    chk("mrst_regrant_port", arb_grant, 1'b0);
    $display("reset mid-burst done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
